// File: rtl/input_conditioner_pkg.sv
// Shared types and sizing helpers for the raw-input conditioner.
package input_conditioner_pkg;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int DEB_MS_DEFAULT = 10;

  typedef enum logic {DEB_STABLE, DEB_PENDING} deb_state_e;

  // Counter width for a modulo-n count, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_debounce_ch.sv
// One conditioner channel: synchroniser, tick-based debounce, level and edge pulses.
module input_debounce_ch
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_TICKS   = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEB_TICKS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   differs;
  logic                   last;
  logic                   level_d;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_cur;
  deb_state_e             state;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign differs = sync != level;
  // The count only carries meaning while a change is pending.
  assign cnt_cur = (state == DEB_PENDING) ? cnt : '0;
  assign last    = cnt_cur == CW'(DEB_TICKS - 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= DEB_STABLE;
      cnt   <= '0;
      level <= 1'b0;
    end else if (!differs) begin
      state <= DEB_STABLE;
      cnt   <= '0;
    end else if (tick && last) begin
      state <= DEB_STABLE;
      cnt   <= '0;
      level <= sync;
    end else begin
      state <= DEB_PENDING;
      cnt   <= tick ? cnt_cur + 1'b1 : cnt_cur;
    end
  end

  // Pulses trail the level change by one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
      fall    <= ~level & level_d;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Push-button/switch conditioner: shared debounce tick, per-channel debounce, sticky events, irq.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int NUM_CH      = 5,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV    = input_conditioner_pkg::CLK_HZ_DEFAULT / 1000,
  parameter int DEB_TICKS   = input_conditioner_pkg::DEB_MS_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] i_raw,
  input  logic [NUM_CH-1:0] i_rise_en,
  input  logic [NUM_CH-1:0] i_fall_en,
  input  logic [NUM_CH-1:0] i_irq_en,
  input  logic              i_clr_valid,
  input  logic [NUM_CH-1:0] i_clr_mask,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_events,
  output logic              o_irq
);

  localparam int TW = cnt_width(TICK_DIV);

  logic [TW-1:0]     tcnt;
  logic              tick;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] set;

  // TICK_DIV of 1 keeps tcnt at 0, so tick fires every cycle.
  assign tick = tcnt == TW'(TICK_DIV - 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    input_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_TICKS  (DEB_TICKS)
    ) u_ch (
      .clk  (clk),
      .rstn (rstn),
      .raw  (i_raw[g]),
      .tick (tick),
      .level(o_level[g]),
      .rise (o_rise[g]),
      .fall (o_fall[g])
    );
  end

  assign clr = i_clr_valid ? i_clr_mask : '0;
  assign set = (o_rise & i_rise_en) | (o_fall & i_fall_en);

  // A new event on the same cycle as its clear survives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_events <= '0;
      o_irq    <= 1'b0;
    end else begin
      o_events <= (o_events & ~clr) | set;
      o_irq    <= |(o_events & i_irq_en);
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner against a tick-counting reference model.
module tb_input_conditioner;
  localparam int N = 5, S = 2, TD = 4, D = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0] raw = '0, rise_en = '0, fall_en = '0, irq_en = '0, clr_mask = '0;
  logic clr_valid = 1'b0;
  logic [N-1:0] o_level, o_rise, o_fall, o_events;
  logic o_irq;

  int total = 0;
  int bad = 0;

  // Reference model state: values visible after the most recent edge.
  bit [N-1:0] m_level, m_lvl_d, m_rise, m_fall, m_events;
  bit         m_irq;
  int         m_ticks[N];
  bit [N-1:0] m_q[$];
  int         m_cyc;

  always #5 clk = ~clk;

  input_conditioner #(
    .NUM_CH(N), .SYNC_STAGES(S), .TICK_DIV(TD), .DEB_TICKS(D)
  ) dut (
    .clk(clk), .rstn(rstn), .i_raw(raw), .i_rise_en(rise_en), .i_fall_en(fall_en),
    .i_irq_en(irq_en), .i_clr_valid(clr_valid), .i_clr_mask(clr_mask),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall), .o_events(o_events), .o_irq(o_irq)
  );

  function automatic string st();
    return $sformatf("got lvl=%b rise=%b fall=%b ev=%b irq=%b want lvl=%b rise=%b fall=%b ev=%b irq=%b",
                     o_level, o_rise, o_fall, o_events, o_irq,
                     m_level, m_rise, m_fall, m_events, m_irq);
  endfunction

  task automatic model_reset();
    m_level = '0; m_lvl_d = '0; m_rise = '0; m_fall = '0; m_events = '0; m_irq = 1'b0;
    m_q.delete();
    for (int i = 0; i < S; i++) m_q.push_back('0);
    foreach (m_ticks[i]) m_ticks[i] = 0;
    m_cyc = 0;
  endtask

  // Rules: raw seen S edges late; a change is accepted on the D-th tick it persists through.
  task automatic model_step();
    bit [N-1:0] s, nl;
    bit tick;
    s = m_q.pop_front();
    m_q.push_back(raw);
    tick = (m_cyc % TD) == TD - 1;
    m_cyc++;
    nl = m_level;
    for (int i = 0; i < N; i++) begin
      if (s[i] == m_level[i]) m_ticks[i] = 0;
      else if (tick) begin
        m_ticks[i]++;
        if (m_ticks[i] == D) begin
          nl[i] = s[i];
          m_ticks[i] = 0;
        end
      end
    end
    m_irq    = |(m_events & irq_en);
    m_events = (m_events & ~(clr_valid ? clr_mask : '0)) | (m_rise & rise_en) | (m_fall & fall_en);
    m_rise   = m_level & ~m_lvl_d;
    m_fall   = ~m_level & m_lvl_d;
    m_lvl_d  = m_level;
    m_level  = nl;
  endtask

  task automatic step();
    @(posedge clk);
    if (rstn) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({o_level, o_rise, o_fall, o_events, o_irq} !== '0) begin
      bad++; $display("FAIL reset_values %s", st());
    end
    rstn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      total++;
      if ({o_level, o_rise, o_fall, o_events, o_irq} !== {m_level, m_rise, m_fall, m_events, m_irq}) begin
        bad++; $display("FAIL reset_idle cyc%0d %s", n, st());
      end
    end
  endtask

  task automatic test_clean_step();
    int lvl_n = 0, rise_n = 0, rise_c = 0, fall_c = 0;
    raw[0] = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      step();
      total++;
      if ({o_level, o_rise, o_fall, o_events, o_irq} !== {m_level, m_rise, m_fall, m_events, m_irq}) begin
        bad++; $display("FAIL clean_step cyc%0d %s", n, st());
      end
      if (o_level[0] && lvl_n == 0) lvl_n = n;
      if (o_rise[0]) begin rise_c++; rise_n = n; end
      if (o_fall[0]) fall_c++;
    end
    total++;
    if (lvl_n < 10 || lvl_n > 14) begin
      bad++; $display("FAIL clean_latency got %0d want 10..14", lvl_n);
    end
    total++;
    if (rise_c != 1 || rise_n != lvl_n + 1) begin
      bad++; $display("FAIL clean_rise got count=%0d at=%0d want count=1 at=%0d", rise_c, rise_n, lvl_n + 1);
    end
    total++;
    if (fall_c != 0) begin
      bad++; $display("FAIL clean_no_fall got %0d want 0", fall_c);
    end
  endtask

  task automatic test_bounce();
    int lvl_n = 0, rise_c = 0;
    bit early = 1'b0;
    for (int n = 0; n < 8; n++) begin
      raw[1] = (n < 6);
      step();
      total++;
      if ({o_level, o_rise, o_fall, o_events, o_irq} !== {m_level, m_rise, m_fall, m_events, m_irq}) begin
        bad++; $display("FAIL bounce_phase cyc%0d %s", n, st());
      end
      if (o_level[1] || o_rise[1]) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++; $display("FAIL bounce_early_accept got 1 want 0");
    end
    raw[1] = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      step();
      total++;
      if ({o_level, o_rise, o_fall, o_events, o_irq} !== {m_level, m_rise, m_fall, m_events, m_irq}) begin
        bad++; $display("FAIL bounce_settle cyc%0d %s", n, st());
      end
      if (o_level[1] && lvl_n == 0) lvl_n = n;
      if (o_rise[1]) rise_c++;
    end
    total++;
    if (lvl_n < 10 || lvl_n > 14 || rise_c != 1) begin
      bad++; $display("FAIL bounce_accept got latency=%0d rises=%0d want 10..14 and 1", lvl_n, rise_c);
    end
  endtask

  task automatic test_events_irq();
    bit found = 1'b0;
    rise_en = 5'b00100;
    irq_en  = 5'b00100;
    raw[2]  = 1'b1;
    for (int n = 0; n < 30 && !found; n++) begin
      step();
      total++;
      if ({o_level, o_rise, o_fall, o_events, o_irq} !== {m_level, m_rise, m_fall, m_events, m_irq}) begin
        bad++; $display("FAIL events_wait cyc%0d %s", n, st());
      end
      found = o_rise[2];
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL events_timeout got no rise[2] want rise within 30 cycles");
    end
    step();
    total++;
    if (o_events !== 5'b00100 || o_irq !== 1'b0) begin
      bad++; $display("FAIL events_set got ev=%b irq=%b want ev=00100 irq=0", o_events, o_irq);
    end
    step();
    total++;
    if (o_events !== 5'b00100 || o_irq !== 1'b1) begin
      bad++; $display("FAIL irq_assert got ev=%b irq=%b want ev=00100 irq=1", o_events, o_irq);
    end
    clr_valid = 1'b1; clr_mask = 5'b00100;
    step();
    clr_valid = 1'b0; clr_mask = '0;
    total++;
    if (o_events !== 5'b00000 || o_irq !== 1'b1) begin
      bad++; $display("FAIL events_clear got ev=%b irq=%b want ev=00000 irq=1", o_events, o_irq);
    end
    step();
    total++;
    if (o_irq !== 1'b0 || o_irq !== m_irq) begin
      bad++; $display("FAIL irq_deassert %s", st());
    end
  endtask

  task automatic test_collision();
    bit found = 1'b0;
    rise_en = 5'b01100;
    raw[3]  = 1'b1;
    for (int n = 0; n < 30 && !found; n++) begin
      step();
      total++;
      if ({o_level, o_rise, o_fall, o_events, o_irq} !== {m_level, m_rise, m_fall, m_events, m_irq}) begin
        bad++; $display("FAIL collision_wait cyc%0d %s", n, st());
      end
      found = o_rise[3];
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL collision_timeout got no rise[3] want rise within 30 cycles");
    end
    clr_valid = 1'b1; clr_mask = 5'b01000;
    step();
    clr_valid = 1'b0; clr_mask = '0;
    total++;
    if (o_events[3] !== 1'b1 || o_events !== m_events) begin
      bad++; $display("FAIL collision_set_wins got ev=%b want ev=%b with bit3=1", o_events, m_events);
    end
  endtask

  task automatic test_fall_only();
    int rise_c = 0, fall_c = 0;
    bit ev_on_rise = 1'b0;
    fall_en = 5'b10000;
    for (int ph = 0; ph < 2; ph++) begin
      raw[4] = (ph == 0);
      for (int n = 0; n < 20; n++) begin
        step();
        total++;
        if ({o_level, o_rise, o_fall, o_events, o_irq} !== {m_level, m_rise, m_fall, m_events, m_irq}) begin
          bad++; $display("FAIL fall_only ph%0d cyc%0d %s", ph, n, st());
        end
        if (o_rise[4]) rise_c++;
        if (o_fall[4]) fall_c++;
        if (ph == 0 && o_events[4]) ev_on_rise = 1'b1;
      end
    end
    total++;
    if (rise_c != 1 || fall_c != 1) begin
      bad++; $display("FAIL fall_only_pulses got rise=%0d fall=%0d want 1 and 1", rise_c, fall_c);
    end
    total++;
    if (ev_on_rise || o_events[4] !== 1'b1) begin
      bad++; $display("FAIL fall_only_event got on_rise=%0d final=%b want 0 and 1", ev_on_rise, o_events[4]);
    end
  endtask

  task automatic test_reset_mid();
    int lvl_n = 0, rise_n = 0;
    bit early = 1'b0, armed = 1'b0;
    raw[0] = 1'b0;
    for (int n = 0; n < 20; n++) step();
    raw[0] = 1'b1;
    for (int n = 0; n < 20 && !armed; n++) begin
      step();
      armed = (m_ticks[0] == 1);
    end
    total++;
    if (!armed) begin
      bad++; $display("FAIL reset_mid_arm got no pending count want count 1 within 20 cycles");
    end
    #2 rstn = 1'b0;
    model_reset();
    #1;
    total++;
    if ({o_level, o_rise, o_fall, o_events, o_irq} !== '0) begin
      bad++; $display("FAIL reset_async %s", st());
    end
    repeat (2) step();
    rstn = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      total++;
      if ({o_level, o_rise, o_fall, o_events, o_irq} !== {m_level, m_rise, m_fall, m_events, m_irq}) begin
        bad++; $display("FAIL reset_release cyc%0d %s", n, st());
      end
      if (n <= 10 && (|o_rise || |o_fall)) early = 1'b1;
      if (o_level[0] && lvl_n == 0) lvl_n = n;
      if (o_rise[0] && rise_n == 0) rise_n = n;
    end
    total++;
    if (early) begin
      bad++; $display("FAIL reset_release_pulse got pulse want none");
    end
    total++;
    if (lvl_n < 10 || lvl_n > 14 || rise_n != lvl_n + 1) begin
      bad++; $display("FAIL reset_reaccept got latency=%0d rise_at=%0d want 10..14 and latency+1", lvl_n, rise_n);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 19) == 0) raw[i] = ~raw[i];
      if ($urandom_range(0, 7) == 0) rise_en = N'($urandom);
      if ($urandom_range(0, 7) == 0) fall_en = N'($urandom);
      if ($urandom_range(0, 7) == 0) irq_en  = N'($urandom);
      clr_valid = ($urandom_range(0, 9) == 0);
      clr_mask  = N'($urandom);
      step();
      total++;
      if ({o_level, o_rise, o_fall, o_events, o_irq} !== {m_level, m_rise, m_fall, m_events, m_irq}) begin
        bad++; $display("FAIL random cyc%0d %s", n, st());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_events_irq();
    test_collision();
    test_fall_only();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised conditioner for the board's raw push-button and switch inputs before they reach the GPIO/button peripheral in swervolf_core. It provides per-channel synchronisation, debounce, rising/falling edge detection, sticky event capture with mask-clear, and a single level interrupt. It replaces direct wiring of raw pad levels into the core. Channel count, synchroniser depth and debounce timing are generalised by parameters.

Parameters:
NUM_CH, 5, number of input channels (1..32)
SYNC_STAGES, 2, flip-flop synchroniser depth per channel (>=2)
TICK_DIV, 50000, clk cycles per debounce tick (1 ms at 50 MHz); must be >=1, and 1 gives a tick every cycle
DEB_TICKS, 10, consecutive ticks a changed input must stay stable before it is accepted (>=1)

Ports:
clk  in  1  core clock (clk_core domain)
rstn  in  1  asynchronous active-low reset; asserts asynchronously, releases synchronously to clk
i_raw  in  NUM_CH  asynchronous raw pad levels
i_rise_en  in  NUM_CH  per-channel enable for latching rising-edge events
i_fall_en  in  NUM_CH  per-channel enable for latching falling-edge events
i_irq_en  in  NUM_CH  per-channel interrupt mask
i_clr_valid  in  1  single-cycle strobe: clear the events selected by i_clr_mask
i_clr_mask  in  NUM_CH  write-1-to-clear mask, sampled only while i_clr_valid=1
o_level  out  NUM_CH  debounced level
o_rise  out  NUM_CH  one-cycle pulse on each accepted 0->1 transition
o_fall  out  NUM_CH  one-cycle pulse on each accepted 1->0 transition
o_events  out  NUM_CH  sticky event flags
o_irq  out  1  registered OR of (o_events & i_irq_en)

Behaviour:
- Reset values: all synchroniser flops 0, tick counter 0, per-channel counters 0, o_level 0, o_rise 0, o_fall 0, o_events 0, o_irq 0.
- Synchroniser: i_raw passes through SYNC_STAGES flops to give sync[i]. No other logic samples i_raw.
- Tick prescaler: one shared counter, width $clog2(TICK_DIV) (min 1). It counts 0..TICK_DIV-1. tick=1 for exactly one cycle when the count equals TICK_DIV-1, and the counter wraps to 0 on that cycle. It runs freely from reset release.
- Per-channel debounce has two states:
  - STABLE: sync==level. cnt is held at 0.
  - PENDING: sync!=level.
    - On each tick, cnt increments.
    - When tick=1, cnt==DEB_TICKS-1 and sync still differs, then level<=sync and cnt<=0.
    - If sync returns to equal level on any cycle, cnt<=0 immediately, with no accept.
  - Counter width is $clog2(DEB_TICKS) (min 1). The counter never exceeds DEB_TICKS-1.
- Acceptance latency after a clean input step: SYNC_STAGES cycles plus between (DEB_TICKS-1)*TICK_DIV+1 and DEB_TICKS*TICK_DIV cycles, depending on tick phase.
- o_rise/o_fall are registered. They assert the cycle after o_level changes, for exactly one cycle. They are independent of the enables.
- Events:
  - Set condition: events[i] set when (o_rise[i]&i_rise_en[i]) | (o_fall[i]&i_fall_en[i]).
  - Clear: when i_clr_valid=1, bits with i_clr_mask=1 are cleared.
  - Set and clear on the same bit in the same cycle: set wins, and the bit remains 1.
  - Disabling an enable does not clear an already-set event.
- o_irq: registered one cycle after o_events or i_irq_en changes.
- Inputs held high through reset: level starts at 0, so an o_rise is produced after debounce. Software must clear the resulting events at init.
- Reset asserted mid-debounce: everything returns to its reset value asynchronously. No pulse is generated on release.
- Channels are fully independent. Simultaneous accepts on several channels in the same tick all take effect in that cycle.

Decomposition:
- Package input_conditioner_pkg holds:
  - helper function cnt_width(n), returning max(1,$clog2(n));
  - enum deb_state_e {DEB_STABLE, DEB_PENDING};
  - default constants CLK_HZ_DEFAULT=50_000_000 and DEB_MS_DEFAULT=10.
- Sub-module input_debounce_ch, generated NUM_CH times. It contains the synchroniser, the debounce FSM/counter, level and the pulse registers.
- The top level holds the shared tick prescaler, the event register and irq.

Test Plan:
All scenarios use TICK_DIV=4, DEB_TICKS=3, SYNC_STAGES=2, NUM_CH=5.
1. Clean step: i_raw[0] 0->1 and held. Required: o_level[0] rises 10..14 cycles later; o_rise[0] pulses exactly 1 cycle the next cycle; no o_fall.
2. Bounce: i_raw[1] toggles high for 6 cycles, low for 2, then high. Required: no accept during the bounce; acceptance counts from the last edge; exactly one o_rise[1].
3. Events/irq: i_rise_en=5'b00100, i_irq_en=5'b00100, then press ch2. Required: o_events=5'b00100, o_irq=1 one cycle later. Then i_clr_valid with mask 5'b00100. Required: o_events=0, o_irq=0 one cycle later.
4. Set-vs-clear collision: drive the clear strobe on the cycle o_rise[3] fires with i_rise_en[3]=1. Required: o_events[3] stays 1.
5. Fall only: i_fall_en[4]=1, i_rise_en[4]=0, press then release ch4. Required: o_rise[4] and o_fall[4] each pulse once; o_events[4] sets only on the fall.
6. Reset mid-debounce: drop rstn at cnt=1 on ch0. Required: all outputs 0 asynchronously; no pulse after release; the still-high input is accepted 10..14 cycles after release.
